// File: rtl/fifo_rd_stream_bridge_if.sv
// Read-side bundle for the stream bridge: the FIFO read port plus the
// valid/ready output stream. The bridge uses the master view and the
// environment (FIFO and sink) uses the slave view.
interface fifo_rd_stream_bridge_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  rempty,
    input  rdata,
    output rinc,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output rempty,
    output rdata,
    input  rinc,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream_bridge.sv
// Read-domain consumer of the async FIFO. Pops words and presents them on a
// valid/ready stream. A small credit-controlled buffer covers the FIFO's
// one-cycle read latency, so a read is only issued when its word is
// guaranteed a slot. This lets a continuously ready sink get one word per
// cycle, and back-pressure can never cause an over-read.
module fifo_rd_stream_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic                     enable,
  fifo_rd_stream_bridge_if.master  bus,
  output logic [CNT_WIDTH-1:0]     word_count,
  output logic                     busy
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Two extra bits let occ + inflight - pop be formed without wrap.
  localparam int OW = $clog2(BUF_DEPTH) + 2;

  logic [OW-1:0]         occ_q, occ_d;
  logic                  inflight_q;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

  logic          pop;
  logic          rinc;
  logic [OW-1:0] proj;

  // Pointer increment modulo BUF_DEPTH (depth need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Credit check and next-state: a read is issued only if, after this
  // cycle's pop, there is room for the word that read will return.
  always_comb begin
    pop      = (occ_q != '0) && bus.m_ready;
    proj     = occ_q + OW'(inflight_q) - OW'(pop);
    rinc     = rrst_n && enable && !bus.rempty && (proj < OW'(BUF_DEPTH));
    occ_d    = proj;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (inflight_q) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // Control state; reset discards any in-flight and buffered words.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rinc;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Buffer storage captures the FIFO word the cycle after its read; contents
  // are only meaningful while counted in occ, so no reset is needed.
  always_ff @(posedge rclk) begin
    if (inflight_q) begin
      buf_q[wr_ptr_q] <= bus.rdata;
    end
  end

  assign bus.rinc    = rinc;
  assign bus.m_valid = (occ_q != '0);
  assign bus.m_data  = buf_q[rd_ptr_q];
  assign word_count  = cnt_q;
  assign busy        = (occ_q != '0) || inflight_q;

endmodule

// File: tb/tb_fifo_rd_stream_bridge.sv
// Bench for fifo_rd_stream_bridge: behavioural FIFO with one-cycle read
// latency, a cycle-level occupancy model, and a scoreboard of popped words.
module tb_fifo_rd_stream_bridge;
  localparam int DW = 8;
  localparam int BD = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          enable = 1'b0;
  logic          blk = 1'b0;
  logic [CW-1:0] word_count;
  logic          busy;

  fifo_rd_stream_bridge_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_stream_bridge #(
    .DATA_WIDTH(DW),
    .BUF_DEPTH (BD),
    .CNT_WIDTH (CW)
  ) dut (
    .rclk      (clk),
    .rrst_n    (rrst_n),
    .enable    (enable),
    .bus       (bus),
    .word_count(word_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rinc_pulses = 0;
  int pops = 0;
  int first_rinc = -1;
  int first_valid = -1;
  int first_pop = -1;
  int last_pop = -1;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int            occ_m = 0;
  logic          infl_m = 1'b0;
  logic [CW-1:0] cnt_m = '0;
  logic [DW-1:0] rd_next;
  logic          rd_next_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic          pop_m;
    logic          exp_rinc;
    logic          rinc_s;
    logic [DW-1:0] w;
    bus.rempty = blk || (fq.size() == 0);
    #1;
    pop_m    = rrst_n && (occ_m != 0) && bus.m_ready;
    exp_rinc = rrst_n && enable && !bus.rempty &&
               ((occ_m + int'(infl_m) - int'(pop_m)) < BD);
    chk("rinc", bus.rinc, exp_rinc);
    chk("m_valid", bus.m_valid, occ_m != 0);
    chk("busy", busy, (occ_m != 0) || infl_m);
    chk("word_count", word_count, cnt_m);
    chk("rinc_while_empty", bus.rinc & bus.rempty, 0);
    if (bus.m_valid && first_valid < 0) first_valid = cyc;
    if (pop_m) begin
      if (sb.size() == 0) begin
        chk("pop_without_word", 1, 0);
      end else begin
        w = sb.pop_front();
        chk("m_data", bus.m_data, w);
      end
      cnt_m = cnt_m + 1'b1;
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    rinc_s    = bus.rinc;
    rd_next_v = 1'b0;
    if (rinc_s) begin
      rinc_pulses++;
      if (first_rinc < 0) first_rinc = cyc;
      if (fq.size() != 0) begin
        rd_next   = fq.pop_front();
        rd_next_v = 1'b1;
        sb.push_back(rd_next);
      end
    end
    @(posedge clk);
    if (rrst_n) begin
      occ_m  = occ_m + int'(infl_m) - int'(pop_m);
      infl_m = rinc_s;
    end else begin
      occ_m  = 0;
      infl_m = 1'b0;
    end
    chk("invariant", (occ_m + int'(infl_m)) <= BD, 1);
    #1 bus.rdata = rd_next_v ? rd_next : DW'($urandom);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset(input int n);
    rrst_n = 1'b0;
    occ_m  = 0;
    infl_m = 1'b0;
    cnt_m  = '0;
    sb.delete();
    repeat (n) step();
    rrst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (fq.size() == 0 && sb.size() == 0 && occ_m == 0 && !infl_m) break;
      step();
    end
    chk("drain_left", fq.size() + sb.size(), 0);
  endtask

  int p0;
  int rp;

  initial begin
    bus.rempty  = 1'b1;
    bus.rdata   = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);

    // Reset held with words waiting and a ready sink
    enable = 1'b1;
    bus.m_ready = 1'b1;
    fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
    apply_reset(3);
    fq.delete();

    // Streaming
    first_rinc = -1; first_valid = -1; first_pop = -1; last_pop = -1; pops = 0;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    repeat (8) step();
    chk("stream_latency", first_valid - first_rinc, 2);
    chk("stream_pops", pops, 4);
    chk("stream_back_to_back", last_pop - first_pop, 3);
    chk("stream_count", word_count, 4);
    chk("stream_idle", busy, 0);

    // Back-pressure
    bus.m_ready = 1'b0;
    rinc_pulses = 0;
    for (int i = 0; i < 6; i++) fq.push_back(8'h60 + DW'(i));
    repeat (6) step();
    chk("bp_rinc_pulses", rinc_pulses, 2);
    chk("bp_valid", bus.m_valid, 1);
    chk("bp_head", bus.m_data, 8'h60);
    bus.m_ready = 1'b1;
    p0 = pops; rp = rinc_pulses;
    step();
    chk("bp_one_pop", pops - p0, 1);
    chk("bp_one_refill", rinc_pulses - rp, 1);
    bus.m_ready = 1'b0;
    repeat (3) step();
    chk("bp_full_again", rinc_pulses - rp, 1);
    bus.m_ready = 1'b1;
    drain(30);

    // Empty flag toggling every cycle
    for (int i = 0; i < 8; i++) fq.push_back(8'h70 + DW'(i));
    for (int i = 0; i < 24; i++) begin
      blk = ~blk;
      step();
    end
    blk = 1'b0;
    drain(30);

    // Enable dropped with one word buffered and one in flight
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fq.push_back(8'h80 + DW'(i));
    step();
    step();
    chk("gate_busy", busy, 1);
    chk("gate_valid", bus.m_valid, 1);
    enable = 1'b0;
    bus.m_ready = 1'b1;
    p0 = pops; rp = rinc_pulses;
    repeat (4) step();
    chk("gate_no_rinc", rinc_pulses - rp, 0);
    chk("gate_delivered", pops - p0, 2);
    chk("gate_busy_low", busy, 0);
    chk("gate_fifo_left", fq.size(), 3);
    enable = 1'b1;
    drain(30);

    // Counter wrap, then reset with a read in flight
    apply_reset(1);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 17; i++) fq.push_back(8'h90 + DW'(i));
    drain(40);
    chk("wrap_count", word_count, 1);
    fq.push_back(8'hC0); fq.push_back(8'hC1); fq.push_back(8'hC2);
    step();
    step();
    chk("pre_reset_busy", busy, 1);
    p0 = pops;
    apply_reset(2);
    drain(20);
    chk("post_reset_pops", pops - p0, 1);
    chk("post_reset_count", word_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
